// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - shared encodings and constants for the Maple receive path
package maple_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA
   } state_t;

   localparam int START_PULSES = 4;
   localparam int END_PULSES   = 2;
   localparam int ENTRY_W      = 9;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/maple_rx.sv
// rtl/maple_rx.sv - Maple bus receive decoder with byte FIFO and sticky status
// Optional MAPLE_RX_CHECKSUM_EN adds crc_ok (XOR of all frame bytes is zero).
module maple_rx
   import maple_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_p1,
   input  logic       in_p5,
   input  logic       rx_en,
   output logic [7:0] rx_data,
   output logic       rx_last,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       overflow,
   output logic       frame_err,
`ifdef MAPLE_RX_CHECKSUM_EN
   output logic       crc_ok,
`endif
   input  logic       clr_status
);

   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

   logic a_meta, a_sync, a_prev;
   logic b_meta, b_sync, b_prev;
   logic a_fall, a_rise, b_fall, b_rise, any_edge;

   state_t               state;
   logic [2:0]           pulse_cnt;
   logic                 phase_b;
   logic                 tent;
   logic [1:0]           end_cnt;
   logic [6:0]           shreg;
   logic [2:0]           bit_cnt;
   logic [7:0]           pend;
   logic                 pend_valid;
   logic [TW-1:0]        tmo;
   logic                 push;
   logic [ENTRY_W-1:0]   push_data;
   logic                 commit;
   logic                 bit_val;
   logic [7:0]           nxt_byte;
   logic                 byte_done;
   logic [ENTRY_W-1:0]   head;
   logic                 full;
   logic                 empty;
   logic                 pop_fire;
`ifdef MAPLE_RX_CHECKSUM_EN
   logic [7:0]           acc;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         {a_meta, a_sync, a_prev} <= 3'b111;
         {b_meta, b_sync, b_prev} <= 3'b111;
      end else begin
         a_meta <= in_p1;
         a_sync <= a_meta;
         a_prev <= a_sync;
         b_meta <= in_p5;
         b_sync <= b_meta;
         b_prev <= b_sync;
      end
   end

   assign a_fall   = a_prev & ~a_sync;
   assign a_rise   = ~a_prev & a_sync;
   assign b_fall   = b_prev & ~b_sync;
   assign b_rise   = ~b_prev & b_sync;
   assign any_edge = (a_prev ^ a_sync) | (b_prev ^ b_sync);

   // An A fall with B low is held tentative: a following A rise makes it an end pulse,
   // a following B edge makes it a data 0.
   always_comb begin
      commit  = 1'b0;
      bit_val = 1'b0;
      if (state == DATA) begin
         if (phase_b) begin
            if (b_fall) begin
               commit  = 1'b1;
               bit_val = a_sync;
            end
         end else if (end_cnt == 2'd0) begin
            if (a_fall && b_sync) begin
               commit  = 1'b1;
               bit_val = 1'b1;
            end else if (tent && (b_rise || b_fall)) begin
               commit  = 1'b1;
               bit_val = 1'b0;
            end
         end
      end
   end

   assign nxt_byte  = {shreg, bit_val};
   assign byte_done = commit && (bit_cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         pulse_cnt  <= '0;
         phase_b    <= 1'b0;
         tent       <= 1'b0;
         end_cnt    <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         tmo        <= '0;
         push       <= 1'b0;
         push_data  <= '0;
         frame_err  <= 1'b0;
`ifdef MAPLE_RX_CHECKSUM_EN
         acc        <= '0;
         crc_ok     <= 1'b0;
`endif
      end else begin
         push <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_en && a_fall && b_sync) begin
                  state     <= START;
                  pulse_cnt <= '0;
                  tmo       <= '0;
               end
            end
            START, DATA: begin
               if (!any_edge) begin
                  if (tmo == TMO_MAX) begin
                     frame_err  <= 1'b1;
                     pend_valid <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     tmo <= tmo + 1'b1;
                  end
               end else begin
                  tmo <= '0;
                  if (state == START) begin
                     if (b_fall && !a_sync && pulse_cnt != 3'd7) begin
                        pulse_cnt <= pulse_cnt + 3'd1;
                     end
                     if (a_rise) begin
                        if (pulse_cnt == 3'(START_PULSES)) begin
                           state      <= DATA;
                           phase_b    <= 1'b0;
                           tent       <= 1'b0;
                           end_cnt    <= '0;
                           bit_cnt    <= '0;
                           pend_valid <= 1'b0;
`ifdef MAPLE_RX_CHECKSUM_EN
                           acc        <= '0;
`endif
                        end else begin
                           state <= IDLE;
                        end
                     end
                  end else if (commit) begin
                     shreg   <= nxt_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     phase_b <= ~phase_b;
                     tent    <= 1'b0;
                     if (byte_done) begin
                        pend       <= nxt_byte;
                        pend_valid <= 1'b1;
                        if (pend_valid) begin
                           push      <= 1'b1;
                           push_data <= {1'b0, pend};
                        end
`ifdef MAPLE_RX_CHECKSUM_EN
                        acc <= acc ^ nxt_byte;
`endif
                     end
                  end else if (phase_b) begin
                     if (a_fall && !b_sync) begin
                        frame_err  <= 1'b1;
                        pend_valid <= 1'b0;
                        state      <= IDLE;
                     end
                  end else if (end_cnt != 2'd0 && (b_rise || b_fall)) begin
                     if (b_rise && end_cnt == 2'(END_PULSES) && !tent &&
                         bit_cnt == 3'd0 && pend_valid) begin
                        push      <= 1'b1;
                        push_data <= {1'b1, pend};
`ifdef MAPLE_RX_CHECKSUM_EN
                        crc_ok    <= (acc == 8'd0);
`endif
                     end else begin
                        frame_err <= 1'b1;
                     end
                     pend_valid <= 1'b0;
                     state      <= IDLE;
                  end else if (b_fall && !a_sync) begin
                     frame_err  <= 1'b1;
                     pend_valid <= 1'b0;
                     state      <= IDLE;
                  end else if (a_fall && !b_sync) begin
                     tent <= 1'b1;
                  end else if (a_rise && tent) begin
                     tent <= 1'b0;
                     if (end_cnt != 2'd3) begin
                        end_cnt <= end_cnt + 2'd1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
         if (clr_status) begin
            frame_err <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (rx_ready),
      .wdata (push_data),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign {rx_last, rx_data} = head;
   assign rx_valid           = ~empty;
   assign busy               = (state != IDLE);
   assign pop_fire           = rx_ready && !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (clr_status) begin
         overflow <= 1'b0;
      end else if (push && full && !pop_fire) begin
         overflow <= 1'b1;
      end
   end

endmodule
